// File: rtl/enc_pkg.sv
// Shared types and the quadrature transition classifier for the encoder front end.
package enc_pkg;

  typedef logic [1:0] quad_state_t;

  typedef enum logic {
    INIT,
    TRACK
  } dec_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic valid;
    logic illegal;
    logic dir;
  } quad_step_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a double-bit change is illegal.
  function automatic quad_step_t quad_step(input quad_state_t prev, input quad_state_t cur);
    quad_step_t r;
    r = '0;
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
        r.valid = 1'b1;
        r.dir   = DIR_FWD;
      end
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
        r.valid = 1'b1;
        r.dir   = DIR_REV;
      end
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: r.illegal = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Per-channel synchroniser chain followed by a level debouncer.
module enc_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic system_reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      sync_q   <= '0;
      count    <= '0;
      filtered <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (synced != filtered) begin
        if (count == LAST) begin
          filtered <= synced;
          count    <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/encoder_conditioner.sv
// Quadrature encoder front end: sync/debounce of A/B, x4 decode, position and error.
// Optional index channel (position zeroing) is enabled by defining ENC_INDEX_EN.
module encoder_conditioner
  import enc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned POS_WIDTH       = 32
) (
  input  logic                 clock,
  input  logic                 system_reset,
  input  logic                 enc_a,
  input  logic                 enc_b,
`ifdef ENC_INDEX_EN
  input  logic                 enc_index,
`endif
  input  logic                 error_clear,
  output logic                 step_pulse,
  output logic                 step_dir,
  output logic [POS_WIDTH-1:0] position,
  output logic                 quad_error
);

  localparam int unsigned SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic        a_f;
  logic        b_f;
  logic        index_load;
  quad_state_t cur;
  quad_state_t prev;
  quad_step_t  step;
  dec_state_t  state;
  logic [SW-1:0] settle;

  enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clock        (clock),
    .system_reset (system_reset),
    .raw          (enc_a),
    .filtered     (a_f)
  );

  enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clock        (clock),
    .system_reset (system_reset),
    .raw          (enc_b),
    .filtered     (b_f)
  );

`ifdef ENC_INDEX_EN
  logic idx_f;
  logic idx_q;

  enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_idx (
    .clock        (clock),
    .system_reset (system_reset),
    .raw          (enc_index),
    .filtered     (idx_f)
  );

  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) idx_q <= 1'b0;
    else              idx_q <= idx_f;
  end

  assign index_load = (state == TRACK) && idx_f && !idx_q;
`else
  assign index_load = 1'b0;
`endif

  assign cur  = {a_f, b_f};
  assign step = quad_step(prev, cur);

  always_ff @(posedge clock or posedge system_reset) begin
    if (system_reset) begin
      state      <= INIT;
      settle     <= '0;
      prev       <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      position   <= '0;
      quad_error <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (state == INIT) begin
        // Wait until the filters have caught up with whatever level the pins hold.
        if (settle == SETTLE_LAST) begin
          prev  <= cur;
          state <= TRACK;
        end else begin
          settle <= settle + SW'(1);
        end
      end else begin
        prev <= cur;
        if (step.valid) begin
          step_pulse <= 1'b1;
          step_dir   <= step.dir;
          position   <= (step.dir == DIR_FWD) ? position + POS_WIDTH'(1)
                                              : position - POS_WIDTH'(1);
        end
        if (index_load) position <= '0;
      end
      if ((state == TRACK) && step.illegal) quad_error <= 1'b1;
      else if (error_clear)                 quad_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_conditioner.sv
// Directed bench for encoder_conditioner with a per-cycle reference model.
module tb_encoder_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int W = 8;
  localparam int SETTLE = S + D + 1;
  localparam int HL = S + D;

  logic clock = 1'b0;
  logic system_reset;
  logic enc_a;
  logic enc_b;
`ifdef ENC_INDEX_EN
  logic enc_index;
`endif
  logic error_clear;
  logic step_pulse;
  logic step_dir;
  logic [W-1:0] position;
  logic quad_error;

  always #5 clock = ~clock;

  encoder_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .POS_WIDTH(W)) dut (
    .clock        (clock),
    .system_reset (system_reset),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
`ifdef ENC_INDEX_EN
    .enc_index    (enc_index),
`endif
    .error_clear  (error_clear),
    .step_pulse   (step_pulse),
    .step_dir     (step_dir),
    .position     (position),
    .quad_error   (quad_error)
  );

  int chk = 0;
  int pass = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse = -1;
  int t0 = 0;
  logic [1:0] ab = 2'b00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Gray code position on the quadrature cycle: 00=0, 01=1, 11=2, 10=3.
  function automatic int gpos(input logic [1:0] v);
    return int'({v[1], v[1] ^ v[0]});
  endfunction

  // Reference model: a level is accepted once the delayed pin has disagreed with it D times in a row.
  logic ha [0:HL-1];
  logic hb [0:HL-1];
  logic fa, fb;
  int settle;
  bit track;
  logic [1:0] mprev;
  logic m_pulse, m_dir, m_err;
  logic [W-1:0] m_pos;
`ifdef ENC_INDEX_EN
  logic hi [0:HL-1];
  logic fi, mi_prev;
`endif

  function automatic logic window_flip(input logic h [0:HL-1], input logic f);
    for (int i = S; i < HL; i++) if (h[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    logic [1:0] fcur;
    bit was_track;
    int d;
    cyc++;
    if (system_reset) begin
      for (int i = 0; i < HL; i++) begin ha[i] = 1'b0; hb[i] = 1'b0; end
      fa = 0; fb = 0; settle = 0; track = 0; mprev = 0;
      m_pulse = 0; m_dir = 0; m_err = 0; m_pos = '0;
`ifdef ENC_INDEX_EN
      for (int i = 0; i < HL; i++) hi[i] = 1'b0;
      fi = 0; mi_prev = 0;
`endif
    end else begin
      fcur = {fa, fb};
      was_track = track;
      m_pulse = 0;
      d = 0;
      if (!track) begin
        settle++;
        if (settle == SETTLE) begin track = 1; mprev = fcur; end
      end else begin
        d = (gpos(fcur) - gpos(mprev)) & 3;
        if (d == 1) begin m_pulse = 1; m_dir = 1; m_pos = m_pos + 1'b1; end
        if (d == 3) begin m_pulse = 1; m_dir = 0; m_pos = m_pos - 1'b1; end
        mprev = fcur;
      end
`ifdef ENC_INDEX_EN
      if (was_track && fi && !mi_prev) m_pos = '0;
      mi_prev = fi;
      for (int i = HL - 1; i > 0; i--) hi[i] = hi[i-1];
      hi[0] = enc_index;
      if (window_flip(hi, fi)) fi = ~fi;
`endif
      if (was_track && d == 2) m_err = 1;
      else if (error_clear) m_err = 0;
      for (int i = HL - 1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
      ha[0] = enc_a;
      hb[0] = enc_b;
      if (window_flip(ha, fa)) fa = ~fa;
      if (window_flip(hb, fb)) fb = ~fb;
    end
    #1;
    if (!system_reset) begin
      check("step_pulse", step_pulse, m_pulse);
      check("step_dir", step_dir, m_dir);
      check("position", position, m_pos);
      check("quad_error", quad_error, m_err);
      if (step_pulse === 1'b1) begin
        pulse_cnt++;
        last_pulse = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_ab(input logic [1:0] v);
    @(negedge clock);
    enc_a = v[1];
    enc_b = v[0];
    ab = v;
    t0 = cyc;
  endtask

  task automatic step_to(input logic [1:0] v, input logic exp_dir, input string name);
    int pc;
    pc = pulse_cnt;
    drive_ab(v);
    idle(10);
    check({name, " pulses"}, pulse_cnt - pc, 1);
    check({name, " latency"}, last_pulse - t0, 7);
    check({name, " dir"}, step_dir, exp_dir);
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] v);
    case (v)
      2'b00: return 2'b01;
      2'b01: return 2'b11;
      2'b11: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    system_reset = 1'b1;
    enc_a = 0; enc_b = 0; error_clear = 0;
`ifdef ENC_INDEX_EN
    enc_index = 0;
`endif
    idle(3);
    check("reset step_pulse", step_pulse, 0);
    check("reset step_dir", step_dir, 0);
    check("reset position", position, 0);
    check("reset quad_error", quad_error, 0);
    @(negedge clock) system_reset = 1'b0;
    idle(SETTLE + 3);

    step_to(2'b01, 1, "fwd1");
    step_to(2'b11, 1, "fwd2");
    step_to(2'b10, 1, "fwd3");
    step_to(2'b00, 1, "fwd4");
    check("fwd position", position, 4);

    step_to(2'b10, 0, "rev1");
    step_to(2'b11, 0, "rev2");
    step_to(2'b01, 0, "rev3");
    step_to(2'b00, 0, "rev4");
    check("rev position", position, 0);
    step_to(2'b10, 0, "rev wrap");
    check("wrap position", position, 8'hFF);
    step_to(2'b00, 1, "wrap back");
    check("unwrap position", position, 0);

    pc = pulse_cnt;
    @(negedge clock) enc_a = 1'b1;
    idle(3);
    enc_a = 1'b0;
    idle(12);
    check("glitch pulses", pulse_cnt - pc, 0);
    check("glitch position", position, 0);
    @(negedge clock) enc_a = 1'b1;
    ab = 2'b10;
    idle(4);
    idle(10);
    check("held4 pulses", pulse_cnt - pc, 1);
    check("held4 position", position, 8'hFF);
    step_to(2'b00, 1, "held4 back");

    pc = pulse_cnt;
    drive_ab(2'b11);
    idle(12);
    check("illegal error", quad_error, 1);
    check("illegal pulses", pulse_cnt - pc, 0);
    check("illegal position", position, 0);
    @(negedge clock) error_clear = 1'b1;
    @(negedge clock) error_clear = 1'b0;
    check("cleared error", quad_error, 0);
    drive_ab(2'b00);
    idle(6);
    error_clear = 1'b1;
    @(negedge clock) error_clear = 1'b0;
    check("set beats clear", quad_error, 1);
    @(negedge clock) error_clear = 1'b1;
    @(negedge clock) error_clear = 1'b0;

    step_to(2'b01, 1, "pre1");
    step_to(2'b11, 1, "pre2");
    drive_ab(2'b00);
    idle(10);
    check("pre error", quad_error, 1);
    drive_ab(2'b01);
    idle(7);
    check("pulse before reset", step_pulse, 1);
    check("position before reset", position, 3);
    #2 system_reset = 1'b1;
    #1;
    check("midreset step_pulse", step_pulse, 0);
    check("midreset step_dir", step_dir, 0);
    check("midreset position", position, 0);
    check("midreset quad_error", quad_error, 0);
    @(negedge clock);
    enc_a = 1'b1; enc_b = 1'b1; ab = 2'b11;
    idle(3);
    system_reset = 1'b0;
    pc = pulse_cnt;
    idle(20);
    check("post reset pulses", pulse_cnt - pc, 0);
    check("post reset error", quad_error, 0);

`ifdef ENC_INDEX_EN
    for (int i = 0; i < 37; i++) begin
      drive_ab(next_fwd(ab));
      idle(8);
    end
    check("index pre position", position, 37);
    @(negedge clock) enc_index = 1'b1;
    idle(6);
    enc_index = 1'b0;
    idle(12);
    check("index position", position, 0);
    for (int i = 0; i < 3; i++) begin
      drive_ab(next_fwd(ab));
      idle(8);
    end
    check("index pre2 position", position, 3);
    pc = pulse_cnt;
    drive_ab(next_fwd(ab));
    enc_index = 1'b1;
    idle(6);
    enc_index = 1'b0;
    idle(6);
    check("index+step pulses", pulse_cnt - pc, 1);
    check("index+step position", position, 0);
`else
    drive_ab(next_fwd(ab));
    idle(10);
    check("final step position", position, 1);
`endif

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
